// File: rtl/rank_order_encoder_if.sv
// Signal bundle between an image source / AER sender and rank_order_encoder.
interface rank_order_encoder_if #(
  parameter int IMAGE_SIZE = 784,
  parameter int PIXEL_BITS = 8
);
  localparam int IDX_BITS = ($clog2(IMAGE_SIZE) > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CNT_BITS = $clog2(IMAGE_SIZE + 1);

  logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE;
  logic                             NEW_IMAGE;
  logic                             MODE;
  logic [PIXEL_BITS-1:0]            THRESHOLD;
  logic                             AEROUT_CTRL_BUSY;
  logic [IDX_BITS-1:0]              NEXT_INDEX;
  logic                             FOUND_NEXT_INDEX;
  logic                             ENCODER_RDY;
  logic                             ENCODER_DONE;
  logic                             FIRST_INFERENCE_DONE;
  logic [CNT_BITS-1:0]              SPIKE_COUNT;

  modport master (
    output IMAGE, NEW_IMAGE, MODE, THRESHOLD, AEROUT_CTRL_BUSY,
    input  NEXT_INDEX, FOUND_NEXT_INDEX, ENCODER_RDY, ENCODER_DONE,
           FIRST_INFERENCE_DONE, SPIKE_COUNT
  );

  modport slave (
    input  IMAGE, NEW_IMAGE, MODE, THRESHOLD, AEROUT_CTRL_BUSY,
    output NEXT_INDEX, FOUND_NEXT_INDEX, ENCODER_RDY, ENCODER_DONE,
           FIRST_INFERENCE_DONE, SPIKE_COUNT
  );
endinterface

// File: rtl/rank_order_encoder.sv
// Rank-order encoder: emits pixel indices brightest-first (or dimmest-first),
// one full one-pixel-per-cycle scan per emitted index, with an AER busy handshake.
module rank_order_encoder #(
  parameter int IMAGE_SIZE = 784,
  parameter int PIXEL_BITS = 8
) (
  input logic                 CLK,
  input logic                 RST_N,
  rank_order_encoder_if.slave bus
);
  localparam int IDX_BITS = ($clog2(IMAGE_SIZE) > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CNT_BITS = $clog2(IMAGE_SIZE + 1);
  localparam logic [CNT_BITS-1:0] SIZE_CNT = CNT_BITS'(IMAGE_SIZE);

  typedef enum logic [2:0] {IDLE, SCAN, PRESENT, WAIT_BUSY, DONE} state_t;
  state_t state_reg;

  logic [PIXEL_BITS-1:0] image_pix [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0] img_mem   [IMAGE_SIZE];
  logic [IMAGE_SIZE-1:0] used_reg;
  logic                  mode_reg;
  logic [PIXEL_BITS-1:0] thr_reg;
  logic [CNT_BITS-1:0]   scan_ptr_reg;
  logic [IDX_BITS-1:0]   scan_idx;

  // Registered read stage: holds pixel (scan_ptr_reg - 1) while scan_ptr_reg > 0
  logic [PIXEL_BITS-1:0] rd_pix_reg;
  logic                  rd_used_reg;
  logic [IDX_BITS-1:0]   rd_idx_reg;

  logic                  best_valid_reg, best_valid_next;
  logic [PIXEL_BITS-1:0] best_val_reg, best_val_next;
  logic [IDX_BITS-1:0]   best_idx_reg, best_idx_next;
  logic                  cand_hit;

  logic [IDX_BITS-1:0]   next_index_reg;
  logic                  found_reg;
  logic                  rdy_reg;
  logic                  done_reg;
  logic                  first_done_reg;
  logic [CNT_BITS-1:0]   spike_count_reg;

  for (genvar gi = 0; gi < IMAGE_SIZE; gi++) begin : g_unpack
    assign image_pix[gi] = bus.IMAGE[gi*PIXEL_BITS +: PIXEL_BITS];
  end

  assign scan_idx = scan_ptr_reg[IDX_BITS-1:0];

  always_ff @(posedge CLK) begin
    if (state_reg == IDLE && bus.NEW_IMAGE) begin
      img_mem <= image_pix;
    end
  end

  // Strict comparison keeps the earliest index on ties
  always_comb begin
    cand_hit = 1'b0;
    if (scan_ptr_reg != '0 && !rd_used_reg && rd_pix_reg >= thr_reg) begin
      if (!best_valid_reg) begin
        cand_hit = 1'b1;
      end else if (mode_reg) begin
        cand_hit = rd_pix_reg < best_val_reg;
      end else begin
        cand_hit = rd_pix_reg > best_val_reg;
      end
    end
    best_valid_next = best_valid_reg | cand_hit;
    best_val_next   = cand_hit ? rd_pix_reg : best_val_reg;
    best_idx_next   = cand_hit ? rd_idx_reg : best_idx_reg;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg       <= IDLE;
      used_reg        <= '0;
      mode_reg        <= 1'b0;
      thr_reg         <= '0;
      scan_ptr_reg    <= '0;
      rd_pix_reg      <= '0;
      rd_used_reg     <= 1'b0;
      rd_idx_reg      <= '0;
      best_valid_reg  <= 1'b0;
      best_val_reg    <= '0;
      best_idx_reg    <= '0;
      next_index_reg  <= '0;
      found_reg       <= 1'b0;
      rdy_reg         <= 1'b1;
      done_reg        <= 1'b0;
      first_done_reg  <= 1'b0;
      spike_count_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.NEW_IMAGE) begin
            mode_reg        <= bus.MODE;
            thr_reg         <= bus.THRESHOLD;
            used_reg        <= '0;
            spike_count_reg <= '0;
            scan_ptr_reg    <= '0;
            best_valid_reg  <= 1'b0;
            rdy_reg         <= 1'b0;
            state_reg       <= SCAN;
          end
        end
        SCAN: begin
          best_valid_reg <= best_valid_next;
          best_val_reg   <= best_val_next;
          best_idx_reg   <= best_idx_next;
          if (scan_ptr_reg != SIZE_CNT) begin
            rd_pix_reg   <= img_mem[scan_idx];
            rd_used_reg  <= used_reg[scan_idx];
            rd_idx_reg   <= scan_idx;
            scan_ptr_reg <= scan_ptr_reg + CNT_BITS'(1);
          end else if (best_valid_next) begin
            next_index_reg <= best_idx_next;
            found_reg      <= 1'b1;
            state_reg      <= PRESENT;
          end else begin
            done_reg       <= 1'b1;
            first_done_reg <= 1'b1;
            state_reg      <= DONE;
          end
        end
        PRESENT: begin
          if (bus.AEROUT_CTRL_BUSY) begin
            used_reg[next_index_reg] <= 1'b1;
            spike_count_reg          <= spike_count_reg + CNT_BITS'(1);
            found_reg                <= 1'b0;
            state_reg                <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!bus.AEROUT_CTRL_BUSY) begin
            if (spike_count_reg == SIZE_CNT) begin
              done_reg       <= 1'b1;
              first_done_reg <= 1'b1;
              state_reg      <= DONE;
            end else begin
              scan_ptr_reg   <= '0;
              best_valid_reg <= 1'b0;
              state_reg      <= SCAN;
            end
          end
        end
        DONE: begin
          rdy_reg   <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.NEXT_INDEX           = next_index_reg;
  assign bus.FOUND_NEXT_INDEX     = found_reg;
  assign bus.ENCODER_RDY          = rdy_reg;
  assign bus.ENCODER_DONE         = done_reg;
  assign bus.FIRST_INFERENCE_DONE = first_done_reg;
  assign bus.SPIKE_COUNT          = spike_count_reg;
endmodule

// File: tb/tb_rank_order_encoder.sv
// Bench for rank_order_encoder: fixed vectors, randomized images against a
// sort-based order model, and hand-written handshake/reset sequences.
module tb_rank_order_encoder;
  localparam int N  = 7;
  localparam int PB = 8;
  localparam int IW = N * PB;
  localparam logic [IW-1:0] IMG0 = {8'd3, 8'd255, 8'd0, 8'd200, 8'd50, 8'd200, 8'd10};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rank_order_encoder_if #(.IMAGE_SIZE(N), .PIXEL_BITS(PB)) bus ();
  rank_order_encoder #(.IMAGE_SIZE(N), .PIXEL_BITS(PB)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [IW-1:0]   img;
    logic            md;
    logic [7:0]      thr;
    logic [3:0]      busy_len;
    logic [3:0]      n_exp;
    logic [6:0][2:0] exp_idx;
  } vec_t;

  vec_t vecs [5];
  int   checks = 0;
  int   failures = 0;
  int   got_q[$];
  int   exp_q[$];
  int   first_lat, done_lat;
  bit   done_seen, timed_out;
  bit   fid_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: eligible pixels stably sorted by intensity (ties keep index order)
  task automatic model_order(input logic [IW-1:0] img, input logic md, input logic [7:0] thr);
    int pix[N];
    int pos;
    exp_q.delete();
    for (int i = 0; i < N; i++) pix[i] = int'(img[i*PB +: PB]);
    for (int i = 0; i < N; i++) begin
      if (pix[i] >= int'(thr)) begin
        pos = exp_q.size();
        while (pos > 0 && (md ? (pix[i] < pix[exp_q[pos-1]]) : (pix[i] > pix[exp_q[pos-1]])))
          pos--;
        exp_q.insert(pos, i);
      end
    end
  endtask

  task automatic run_image(input logic [IW-1:0] img, input logic md, input logic [7:0] thr,
                           input int busy_len, input bit scramble);
    int k;
    logic [63:0] r;
    got_q.delete();
    done_seen = 0;
    timed_out = 0;
    first_lat = -1;
    done_lat  = -1;
    k = 0;
    while (!bus.ENCODER_RDY && k < 50) begin tick(); k++; end
    check("ready_before_start", int'(bus.ENCODER_RDY), 1);
    bus.IMAGE = img;
    bus.MODE = md;
    bus.THRESHOLD = thr;
    bus.NEW_IMAGE = 1'b1;
    tick();
    bus.NEW_IMAGE = 1'b0;
    if (scramble) begin
      r = {$urandom(), $urandom()};
      bus.IMAGE = r[IW-1:0];
      bus.MODE = ~md;
      bus.THRESHOLD = r[63:56];
    end
    k = 0;
    while (!done_seen && !timed_out) begin
      if (bus.FOUND_NEXT_INDEX) begin
        if (first_lat < 0) begin
          first_lat = k;
          check("fid_before_done", int'(bus.FIRST_INFERENCE_DONE), int'(fid_model));
        end
        got_q.push_back(int'(bus.NEXT_INDEX));
        bus.AEROUT_CTRL_BUSY = 1'b1;
        if (scramble) bus.NEW_IMAGE = 1'b1;
        for (int b = 0; b < busy_len; b++) begin
          tick();
          k++;
          if (b == 0) check("ack_drops_found", int'(bus.FOUND_NEXT_INDEX), 0);
        end
        bus.AEROUT_CTRL_BUSY = 1'b0;
        bus.NEW_IMAGE = 1'b0;
      end else if (bus.ENCODER_DONE) begin
        done_seen = 1;
        done_lat = k;
      end else begin
        tick();
        k++;
      end
      if (k > 2000) timed_out = 1;
    end
    if (done_seen) begin
      tick();
      check("done_one_cycle", int'(bus.ENCODER_DONE), 0);
      check("ready_after_done", int'(bus.ENCODER_RDY), 1);
      check("fid_after_done", int'(bus.FIRST_INFERENCE_DONE), 1);
      fid_model = 1;
    end
    $display("run mode=%0d thr=%0d busy=%0d spikes=%0d first_lat=%0d",
             md, thr, busy_len, got_q.size(), first_lat);
  endtask

  task automatic verify_run(input string tag);
    check({tag, "_timeout"}, int'(timed_out), 0);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_idx"}, got_q[i], exp_q[i]);
    check({tag, "_spike_count"}, int'(bus.SPIKE_COUNT), exp_q.size());
    if (exp_q.size() > 0) check({tag, "_first_lat"}, first_lat, N + 1);
    else check({tag, "_done_lat"}, done_lat, N + 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fid_model = 0;
  endtask

  task automatic start_img0(input logic md, input logic busy);
    bus.IMAGE = IMG0;
    bus.MODE = md;
    bus.THRESHOLD = 8'd0;
    bus.AEROUT_CTRL_BUSY = busy;
    bus.NEW_IMAGE = 1'b1;
    tick();
    bus.NEW_IMAGE = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] img;
    logic          md;
    logic [7:0]    thr;
    int            k, hi, acks;

    vecs[0] = '{img: IMG0, md: 1'b0, thr: 8'd0,  busy_len: 4'd3, n_exp: 4'd7,
                exp_idx: {3'd4, 3'd6, 3'd0, 3'd2, 3'd3, 3'd1, 3'd5}};
    vecs[1] = '{img: IMG0, md: 1'b1, thr: 8'd0,  busy_len: 4'd3, n_exp: 4'd7,
                exp_idx: {3'd5, 3'd3, 3'd1, 3'd2, 3'd0, 3'd6, 3'd4}};
    vecs[2] = '{img: IMG0, md: 1'b0, thr: 8'd40, busy_len: 4'd3, n_exp: 4'd4,
                exp_idx: {3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 3'd5}};
    vecs[3] = '{img: '0,   md: 1'b0, thr: 8'd1,  busy_len: 4'd3, n_exp: 4'd0,
                exp_idx: '0};
    vecs[4] = '{img: IMG0, md: 1'b1, thr: 8'd40, busy_len: 4'd1, n_exp: 4'd4,
                exp_idx: {3'd0, 3'd0, 3'd0, 3'd5, 3'd3, 3'd1, 3'd2}};

    bus.IMAGE = '0;
    bus.NEW_IMAGE = 1'b0;
    bus.MODE = 1'b0;
    bus.THRESHOLD = '0;
    bus.AEROUT_CTRL_BUSY = 1'b0;
    fid_model = 0;

    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_next_index", int'(bus.NEXT_INDEX), 0);
    check("rst_found", int'(bus.FOUND_NEXT_INDEX), 0);
    check("rst_rdy", int'(bus.ENCODER_RDY), 1);
    check("rst_done", int'(bus.ENCODER_DONE), 0);
    check("rst_fid", int'(bus.FIRST_INFERENCE_DONE), 0);
    check("rst_spike_count", int'(bus.SPIKE_COUNT), 0);

    // First vector starts on the very first edge with reset released
    rst_n = 1'b1;
    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      for (int j = 0; j < int'(vecs[v].n_exp); j++) exp_q.push_back(int'(vecs[v].exp_idx[j]));
      run_image(vecs[v].img, vecs[v].md, vecs[v].thr, int'(vecs[v].busy_len), 1'b0);
      verify_run($sformatf("vec%0d", v));
    end

    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < N; p++) img[p*PB +: PB] = 8'($urandom_range(0, 7) * 36);
      md  = 1'($urandom_range(0, 1));
      thr = (r % 3 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      model_order(img, md, thr);
      run_image(img, md, thr, $urandom_range(1, 3), 1'b1);
      verify_run("rand");
    end

    // Busy held long after the first acknowledge
    start_img0(1'b0, 1'b0);
    k = 0;
    while (!bus.FOUND_NEXT_INDEX && k < 100) begin tick(); k++; end
    check("hold_first_lat", k, N + 1);
    check("hold_first_idx", int'(bus.NEXT_INDEX), 5);
    bus.AEROUT_CTRL_BUSY = 1'b1;
    tick();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.FOUND_NEXT_INDEX) hi++;
      tick();
    end
    check("hold_found_low", hi, 0);
    bus.AEROUT_CTRL_BUSY = 1'b0;
    k = 0;
    while (!bus.FOUND_NEXT_INDEX && k < 100) begin tick(); k++; end
    // one edge to sample busy low, then a full scan of N+1 edges
    check("hold_relatency", k, N + 2);
    check("hold_second_idx", int'(bus.NEXT_INDEX), 1);
    $display("seq hold: second index %0d after %0d cycles", bus.NEXT_INDEX, k);
    do_reset();

    // Busy already high when the first index is presented
    start_img0(1'b1, 1'b1);
    k = 0;
    while (!bus.FOUND_NEXT_INDEX && k < 100) begin tick(); k++; end
    check("imm_lat", k, N + 1);
    check("imm_idx", int'(bus.NEXT_INDEX), 4);
    tick();
    check("imm_found_one_cycle", int'(bus.FOUND_NEXT_INDEX), 0);
    check("imm_spike_count", int'(bus.SPIKE_COUNT), 1);
    bus.AEROUT_CTRL_BUSY = 1'b0;
    $display("seq immediate ack: index 4 taken in one cycle");
    do_reset();

    // Reset in the middle of the third scan, then a clean full run
    start_img0(1'b0, 1'b0);
    acks = 0;
    k = 0;
    while (acks < 2 && k < 500) begin
      if (bus.FOUND_NEXT_INDEX) begin
        bus.AEROUT_CTRL_BUSY = 1'b1;
        tick();
        bus.AEROUT_CTRL_BUSY = 1'b0;
        acks++;
      end
      tick();
      k++;
    end
    check("midscan_acks", acks, 2);
    repeat (3) tick();
    do_reset();
    check("midscan_rst_rdy", int'(bus.ENCODER_RDY), 1);
    check("midscan_rst_fid", int'(bus.FIRST_INFERENCE_DONE), 0);
    check("midscan_rst_spikes", int'(bus.SPIKE_COUNT), 0);
    check("midscan_rst_found", int'(bus.FOUND_NEXT_INDEX), 0);
    exp_q.delete();
    for (int j = 0; j < 7; j++) exp_q.push_back(int'(vecs[0].exp_idx[j]));
    run_image(IMG0, 1'b0, 8'd0, 3, 1'b0);
    verify_run("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
